rename_register_file: RTL and testbench
=======================================

// Module: rename_register_file
// PURPOSE
//   Architectural register file plus per-register rename tag table; responder for the reorder buffer's launch,
//   commit and dependency-query interface. Launch records which ROB entry will produce a register.
//   Commit writes the retired value and releases the tag if still owned. Queries return the owning tag (0 = none) and value.
// PARAMETERS
//   REG_NUM       32  architectural registers; x0 hardwired to zero
//   ROB_ID_WIDTH  5   ROB tag width; tag 0 reserved as "no dependency" (ROB ids 1..31)
//   DATA_WIDTH    32  register value width
// PORTS
//   clk_in            in   1    system clock; all state updates on posedge
//   rst_in            in   1    asynchronous, active-low reset
//   rdy_in            in   1    ready; when low all state holds (reset still acts)
//   clear_in          in   1    ROB flush (mispredict); drops all rename tags
//   launch_ready_in   in   1    ROB issues instruction with rd
//   launch_rob_id_in  in   5    ROB tag of launching instruction
//   launch_reg_id_in  in   5    destination register
//   commit_ready_in   in   1    ROB retires instruction with rd
//   commit_rob_id_in  in   5    ROB tag of retiring instruction
//   commit_reg_id_in  in   5    destination register
//   commit_value_in   in   32   retired value
//   ask_rd_1_in       in   5    query register, port 1
//   ask_rd_2_in       in   5    query register, port 2
//   dep_rd_1_out      out  5    owning ROB tag of ask_rd_1 (0 = value is architectural)
//   dep_value_1_out   out  32   architectural value of ask_rd_1
//   dep_rd_2_out      out  5    as port 1, for ask_rd_2
//   dep_value_2_out   out  32   as port 1, for ask_rd_2
//   commit_cnt_out    out  32   number of commits applied since reset (wraps mod 2^32)
// BEHAVIOUR
//   - Reset (rst_in=0, async): all values 0, all tags 0, commit_cnt_out 0; read ports then give dep 0, value 0.
//   - Reads combinational from current (pre-edge) state; no bypass of same-cycle launch or commit:
//     an instruction reading its own rd (addi x1,x1,1) must see the previous tag. ROB covers commit forwarding.
//   - ask_rd = 0 -> dep 0, value 0, always.
//   - Launch (rdy_in, !clear_in, launch_ready_in, reg != 0): tag[reg] <= launch_rob_id. reg 0 ignored.
//   - Commit (rdy_in, commit_ready_in, reg != 0): value[reg] <= commit_value; if tag[reg]==commit_rob_id
//     then tag[reg] <= 0, else tag kept (younger producer owns it). commit_cnt_out += 1 on every commit_ready_in
//     with rdy_in, including reg 0.
//   - Launch and commit same reg same cycle: value written, tag <= launch_rob_id (launch wins over release).
//   - clear_in with rdy_in: every tag <= 0; same-cycle launch ignored; same-cycle commit still writes value/counter.
//   - rdy_in=0: no updates, inputs ignored, outputs still reflect held state.
//   - Latency: launch/commit visible on read ports the cycle after the accepting edge.
//   - Tag 0 on launch_rob_id is illegal input; behaviour undefined, no check required.
// TESTING
//   1 reset: rst_in=0 mid-run after writes -> all reads dep 0 value 0, commit_cnt_out 0 asynchronously.
//   2 launch x5 tag 3, next cycle ask x5 -> dep 3; commit x5 tag 3 val 0x1234 -> next cycle dep 0 value 0x1234.
//   3 launch x7 tag 4, launch x7 tag 9, commit x7 tag 4 val 0xAA -> dep 9, value 0xAA.
//   4 same cycle launch x2 tag 6 + commit x2 tag 1 val 0x55 (tag[x2]=1) -> dep 6, value 0x55; same-cycle read shows dep 1.
//   5 launch x1..x4 tags 1..4, clear_in with launch x8 tag 5 -> all tags 0, x8 dep 0; x0 launch/commit -> x0 stays 0 dep 0.
//   6 rdy_in=0 with launch x3 tag 2 + commit -> no change, commit_cnt_out unchanged; rdy_in=1 repeat -> applied, cnt+1.

Source files
------------

// File: rtl/rename_register_file.sv
// Architectural register file with a per-register rename tag table.
// Launch claims a register for a ROB entry; commit writes the value and releases the claim if still owned.

module rename_reg_entry #(
    parameter int ROB_ID_WIDTH = 5,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    launch_hit,
    input  logic [ROB_ID_WIDTH-1:0] launch_rob_id,
    input  logic                    commit_hit,
    input  logic [ROB_ID_WIDTH-1:0] commit_rob_id,
    input  logic [DATA_WIDTH-1:0]   commit_value,
    output logic [ROB_ID_WIDTH-1:0] tag,
    output logic [DATA_WIDTH-1:0]   value
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tag   <= '0;
            value <= '0;
        end else if (rdy_in) begin
            if (commit_hit)
                value <= commit_value;
            // Flush beats launch; launch beats release so a younger producer keeps ownership.
            if (clear_in)
                tag <= '0;
            else if (launch_hit)
                tag <= launch_rob_id;
            else if (commit_hit && tag == commit_rob_id)
                tag <= '0;
        end
    end
endmodule

module rename_register_file #(
    parameter int REG_NUM      = 32,
    parameter int ROB_ID_WIDTH = 5,
    parameter int DATA_WIDTH   = 32,
    localparam int REG_ID_W    = $clog2(REG_NUM)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    launch_ready_in,
    input  logic [ROB_ID_WIDTH-1:0] launch_rob_id_in,
    input  logic [REG_ID_W-1:0]     launch_reg_id_in,
    input  logic                    commit_ready_in,
    input  logic [ROB_ID_WIDTH-1:0] commit_rob_id_in,
    input  logic [REG_ID_W-1:0]     commit_reg_id_in,
    input  logic [DATA_WIDTH-1:0]   commit_value_in,
    input  logic [REG_ID_W-1:0]     ask_rd_1_in,
    input  logic [REG_ID_W-1:0]     ask_rd_2_in,
    output logic [ROB_ID_WIDTH-1:0] dep_rd_1_out,
    output logic [DATA_WIDTH-1:0]   dep_value_1_out,
    output logic [ROB_ID_WIDTH-1:0] dep_rd_2_out,
    output logic [DATA_WIDTH-1:0]   dep_value_2_out,
    output logic [31:0]             commit_cnt_out
);
    logic [REG_NUM-1:0][ROB_ID_WIDTH-1:0] tag_q;
    logic [REG_NUM-1:0][DATA_WIDTH-1:0]   value_q;

    // x0 has no storage: it reads as tag 0, value 0 and silently drops writes.
    assign tag_q[0]   = '0;
    assign value_q[0] = '0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
        rename_reg_entry #(
            .ROB_ID_WIDTH(ROB_ID_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH)
        ) u_entry (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .rdy_in       (rdy_in),
            .clear_in     (clear_in),
            .launch_hit   (launch_ready_in && launch_reg_id_in == REG_ID_W'(r)),
            .launch_rob_id(launch_rob_id_in),
            .commit_hit   (commit_ready_in && commit_reg_id_in == REG_ID_W'(r)),
            .commit_rob_id(commit_rob_id_in),
            .commit_value (commit_value_in),
            .tag          (tag_q[r]),
            .value        (value_q[r])
        );
    end

    // Reads see pre-edge state only; same-cycle forwarding is the ROB's job.
    assign dep_rd_1_out    = tag_q[ask_rd_1_in];
    assign dep_value_1_out = value_q[ask_rd_1_in];
    assign dep_rd_2_out    = tag_q[ask_rd_2_in];
    assign dep_value_2_out = value_q[ask_rd_2_in];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            commit_cnt_out <= '0;
        else if (rdy_in && commit_ready_in)
            commit_cnt_out <= commit_cnt_out + 32'd1;
    end
endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: hand-computed tags, values and commit counts.

module tb_rename_register_file;
    logic        clk_in = 0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        launch_ready_in;
    logic [4:0]  launch_rob_id_in;
    logic [4:0]  launch_reg_id_in;
    logic        commit_ready_in;
    logic [4:0]  commit_rob_id_in;
    logic [4:0]  commit_reg_id_in;
    logic [31:0] commit_value_in;
    logic [4:0]  ask_rd_1_in;
    logic [4:0]  ask_rd_2_in;
    logic [4:0]  dep_rd_1_out;
    logic [31:0] dep_value_1_out;
    logic [4:0]  dep_rd_2_out;
    logic [31:0] dep_value_2_out;
    logic [31:0] commit_cnt_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    rename_register_file dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .launch_ready_in (launch_ready_in),
        .launch_rob_id_in(launch_rob_id_in),
        .launch_reg_id_in(launch_reg_id_in),
        .commit_ready_in (commit_ready_in),
        .commit_rob_id_in(commit_rob_id_in),
        .commit_reg_id_in(commit_reg_id_in),
        .commit_value_in (commit_value_in),
        .ask_rd_1_in     (ask_rd_1_in),
        .ask_rd_2_in     (ask_rd_2_in),
        .dep_rd_1_out    (dep_rd_1_out),
        .dep_value_1_out (dep_value_1_out),
        .dep_rd_2_out    (dep_rd_2_out),
        .dep_value_2_out (dep_value_2_out),
        .commit_cnt_out  (commit_cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear_in        = 0;
        launch_ready_in = 0;
        commit_ready_in = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic launch(input logic [4:0] rg, input logic [4:0] id);
        launch_ready_in  = 1;
        launch_reg_id_in = rg;
        launch_rob_id_in = id;
    endtask

    task automatic commit(input logic [4:0] rg, input logic [4:0] id, input logic [31:0] v);
        commit_ready_in  = 1;
        commit_reg_id_in = rg;
        commit_rob_id_in = id;
        commit_value_in  = v;
    endtask

    task automatic look(input string tag, input logic [4:0] rg, input logic [4:0] dep, input logic [31:0] v);
        ask_rd_1_in = rg;
        #1;
        chk({tag, "_dep"}, 32'(dep_rd_1_out), 32'(dep));
        chk({tag, "_val"}, dep_value_1_out, v);
    endtask

    initial begin
        rst_in = 0; rdy_in = 1; idle();
        launch_rob_id_in = 0; launch_reg_id_in = 0;
        commit_rob_id_in = 0; commit_reg_id_in = 0; commit_value_in = 0;
        ask_rd_1_in = 0; ask_rd_2_in = 0;
        #12;
        look("rst_x5", 5'd5, 5'd0, 32'h0);
        chk("rst_cnt", commit_cnt_out, 32'd0);
        @(negedge clk_in); rst_in = 1;
        #1;

        // launch then commit with matching tag releases
        launch(5'd5, 5'd3); tick();
        look("t2_launch", 5'd5, 5'd3, 32'h0);
        commit(5'd5, 5'd3, 32'h1234); tick();
        look("t2_commit", 5'd5, 5'd0, 32'h1234);
        chk("t2_cnt", commit_cnt_out, 32'd1);

        // older commit must not release a younger producer's tag
        launch(5'd7, 5'd4); tick();
        launch(5'd7, 5'd9); tick();
        commit(5'd7, 5'd4, 32'hAA); tick();
        look("t3", 5'd7, 5'd9, 32'hAA);
        chk("t3_cnt", commit_cnt_out, 32'd2);

        // same-cycle launch + commit on one reg: launch wins, read sees old tag
        launch(5'd2, 5'd1); tick();
        launch(5'd2, 5'd6); commit(5'd2, 5'd1, 32'h55);
        ask_rd_2_in = 5'd2;
        #1;
        chk("t4_same_cycle_dep", 32'(dep_rd_2_out), 32'd1);
        chk("t4_same_cycle_val", dep_value_2_out, 32'h0);
        tick();
        chk("t4_dep", 32'(dep_rd_2_out), 32'd6);
        chk("t4_val", dep_value_2_out, 32'h55);
        chk("t4_cnt", commit_cnt_out, 32'd3);

        // flush drops every tag, ignores launch, still takes commit
        for (int i = 1; i <= 4; i++) begin
            launch(5'(i), 5'(i)); tick();
        end
        look("t5_pre_x4", 5'd4, 5'd4, 32'h0);
        clear_in = 1; launch(5'd8, 5'd5); commit(5'd9, 5'd0, 32'h99); tick();
        for (int i = 1; i <= 4; i++) begin
            ask_rd_1_in = 5'(i);
            #1;
            chk("t5_clr_dep", 32'(dep_rd_1_out), 32'd0);
        end
        look("t5_x2", 5'd2, 5'd0, 32'h55);
        look("t5_x7", 5'd7, 5'd0, 32'hAA);
        look("t5_x8", 5'd8, 5'd0, 32'h0);
        look("t5_x9", 5'd9, 5'd0, 32'h99);
        chk("t5_clr_cnt", commit_cnt_out, 32'd4);
        launch(5'd0, 5'd7); commit(5'd0, 5'd7, 32'hDEAD); tick();
        look("t5_x0", 5'd0, 5'd0, 32'h0);
        ask_rd_2_in = 5'd0;
        #1;
        chk("t5_x0_p2_dep", 32'(dep_rd_2_out), 32'd0);
        chk("t5_x0_p2_val", dep_value_2_out, 32'h0);
        chk("t5_x0_cnt", commit_cnt_out, 32'd5);

        // stall: nothing applied while rdy_in low
        rdy_in = 0; launch(5'd3, 5'd2); commit(5'd3, 5'd5, 32'h77); tick();
        look("t6_stall", 5'd3, 5'd0, 32'h0);
        chk("t6_stall_cnt", commit_cnt_out, 32'd5);
        rdy_in = 1; launch(5'd3, 5'd2); commit(5'd3, 5'd5, 32'h77); tick();
        look("t6_run", 5'd3, 5'd2, 32'h77);
        chk("t6_run_cnt", commit_cnt_out, 32'd6);

        // asynchronous mid-run reset, away from any clock edge
        @(negedge clk_in); #2;
        rst_in = 0;
        #1;
        look("t1_x3", 5'd3, 5'd0, 32'h0);
        look("t1_x5", 5'd5, 5'd0, 32'h0);
        look("t1_x7", 5'd7, 5'd0, 32'h0);
        chk("t1_cnt", commit_cnt_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
